lcg_vector_source: RTL and testbench
====================================

Name: lcg_vector_source

Overview:
- Hardware stimulus source that sits directly upstream of the fuzz DUT and produces its flat input vector (in_flat).
- Generates each vector with the team's deterministic 32-bit LCG: next = state*0x41C64E6D + 0x3039, mod 2^32.
- Packs one LCG word per cycle, LSW first, into a WIDTH-bit vector; the top chunk is truncated.
- Hands each finished vector downstream over a valid/ready handshake, and runs for a programmed number of vectors per start.

Parameters:
WIDTH, 267, width of the produced flat vector (>=1)
WORDS, ceil(WIDTH/32) (derived, not overridable), number of LCG words per vector; 9 at default
TOP_BITS, WIDTH-32*(WORDS-1) (derived), bits used from the last word; 11 at default

Ports:
clk  in  1  single clock; all state changes on its rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  begin a run; sampled only in IDLE
seed  in  32  initial LCG state, latched when start is accepted
num_vectors  in  32  vectors per run, latched when start is accepted
vec_valid  out  1  vec_data holds a complete vector
vec_ready  in  1  downstream accepts the vector
vec_data  out  WIDTH  packed vector; word k at [32k+31:32k]; last word uses rng[TOP_BITS-1:0]
vec_index  out  32  count of vectors accepted in the current run
rng_state_o  out  32  current LCG state
busy  out  1  high in FILL or PRESENT
done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (async, takes effect immediately, mid-run included):
  - state=IDLE
  - vec_valid=0, vec_data=0, vec_index=0, rng_state_o=0, busy=0, done=0
  - all internal counters cleared
- States: IDLE, FILL, PRESENT, DONE.
- IDLE:
  - On start=1: latch seed into rng and num_vectors into the run length; clear vec_index and word_idx.
  - If num_vectors==0, go to DONE; otherwise go to FILL.
  - start is ignored in every other state.
- FILL, one word per cycle:
  - rng <= rng*0x41C64E6D+0x3039, truncated to 32 bits.
  - The new rng value is written into word word_idx of vec_data; word_idx increments.
  - The last word writes only its low TOP_BITS bits.
  - After word WORDS-1 is written, go to PRESENT.
  - vec_valid=0 throughout; vec_data may change only while vec_valid=0.
- PRESENT:
  - vec_valid=1; vec_data and rng_state_o are held stable while vec_ready=0. No timeout.
  - Handshake (vec_valid&&vec_ready at an edge): vec_index increments. If the new vec_index equals the run length, go to DONE; else clear word_idx and go to FILL.
- DONE: done=1 for exactly one cycle, then IDLE. vec_data and vec_index keep their last values until the next accepted start.
- Latency and throughput:
  - Start accepted at edge E0 -> vec_valid visible after edge E(WORDS), i.e. 9 edges at default.
  - With vec_ready held high, one vector every WORDS+1 cycles.
- LCG sequence continuity: the LCG is never reseeded mid-run. Vector n uses LCG steps n*WORDS+1 .. n*WORDS+WORDS after the seed.
- Arithmetic:
  - Multiply and add are modulo 2^32; no saturation.
  - vec_index wraps at 2^32. This is unreachable in practice because the run ends at num_vectors.
- Simultaneous events:
  - start while busy: ignored.
  - vec_ready=1 outside PRESENT: no effect.
  - vec_ready already high when PRESENT is entered: handshake completes on the first PRESENT edge.

Test Plan:
- Reset mid-operation: assert rst_n=0 during PRESENT -> all outputs 0 immediately (before the next clk edge); start after release begins a fresh run from the newly latched seed.
- Basic vector: seed=0, num_vectors=1, vec_ready=1 -> vec_valid rises 9 edges after start.
  - vec_data[31:0]=0x00003039, vec_data[63:32]=0xD3DC167E.
  - vec_data[266:256] = low 11 bits of LCG step 9.
  - done pulses for one cycle after the handshake; vec_index=1.
- Backpressure: seed=0, num_vectors=2, vec_ready=0 for 20 cycles -> vec_data, vec_valid and rng_state_o are stable for all 20 cycles.
  - On release, the second vector's word 0 equals LCG step 10 from seed 0.
- Zero-length run: num_vectors=0, start=1 -> IDLE->DONE->IDLE. Single done pulse; vec_valid never asserts; vec_index=0.
- Start while busy: pulse start with a different seed during FILL -> ignored; the output sequence matches the original seed bit-exactly against the software LCG model.
- Full run: seed=3289233844, num_vectors=100, vec_ready randomly toggled -> 100 vectors that match the golden software LCG packing exactly; vec_index ends at 100; exactly one done pulse.

Source files
------------

// File: rtl/lcg_vector_source.sv
// Stimulus source for the fuzz DUT: packs successive 32-bit LCG words into a
// WIDTH-bit vector, LSW first, and hands each vector downstream over valid/ready.
module lcg_vector_source #(
  parameter int WIDTH = 267
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [31:0]      num_vectors,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [WIDTH-1:0] vec_data,
  output logic [31:0]      vec_index,
  output logic [31:0]      rng_state_o,
  output logic             busy,
  output logic             done
);

  localparam int          WORDS    = (WIDTH + 31) / 32;
  localparam int          TOP_BITS = WIDTH - 32 * (WORDS - 1);
  localparam int          LAST_LO  = 32 * (WORDS - 1);
  localparam logic [31:0] LAST_IDX = 32'(WORDS - 1);
  localparam logic [31:0] LCG_MUL  = 32'h41C6_4E6D;
  localparam logic [31:0] LCG_INC  = 32'h0000_3039;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PRESENT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [31:0]      rng;
  logic [31:0]      rng_next;
  logic [31:0]      run_len;
  logic [31:0]      word_idx;
  logic [WIDTH-1:0] fill_data;
  logic             last_word;
  logic             run_end;

  // Multiply and add wrap naturally at 32 bits.
  assign rng_next  = rng * LCG_MUL + LCG_INC;
  assign last_word = (word_idx == LAST_IDX);
  assign run_end   = ((vec_index + 32'd1) == run_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (num_vectors == 32'd0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (last_word) begin
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (vec_ready) begin
          state_next = run_end ? DONE : FILL;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The final word is truncated so the vector never grows past WIDTH bits.
  always_comb begin
    fill_data = vec_data;
    for (int k = 0; k < WORDS - 1; k++) begin
      if (word_idx == 32'(k)) begin
        fill_data[32*k +: 32] = rng_next;
      end
    end
    if (last_word) begin
      fill_data[LAST_LO +: TOP_BITS] = rng_next[TOP_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rng       <= '0;
      run_len   <= '0;
      word_idx  <= '0;
      vec_data  <= '0;
      vec_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rng       <= seed;
            run_len   <= num_vectors;
            vec_index <= '0;
            word_idx  <= '0;
          end
        end
        FILL: begin
          rng      <= rng_next;
          vec_data <= fill_data;
          word_idx <= last_word ? 32'd0 : word_idx + 32'd1;
        end
        PRESENT: begin
          if (vec_ready) begin
            vec_index <= vec_index + 32'd1;
            word_idx  <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign vec_valid   = (state == PRESENT);
  assign busy        = (state == FILL) || (state == PRESENT);
  assign done        = (state == DONE);
  assign rng_state_o = rng;

endmodule

// File: tb/tb_lcg_vector_source.sv
// Randomized bench for lcg_vector_source: every presented vector is compared
// against a software LCG packing model computed from the seed.
module tb_lcg_vector_source;

  localparam int WIDTH    = 267;
  localparam int WORDS    = (WIDTH + 31) / 32;
  localparam int TOP_BITS = WIDTH - 32 * (WORDS - 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      seed = '0;
  logic [31:0]      num_vectors = '0;
  logic             vec_valid;
  logic             vec_ready = 1'b0;
  logic [WIDTH-1:0] vec_data;
  logic [31:0]      vec_index;
  logic [31:0]      rng_state_o;
  logic             busy;
  logic             done;

  int n_vectors = 0;
  int n_miscompares = 0;

  lcg_vector_source #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .num_vectors(num_vectors),
    .vec_valid  (vec_valid),
    .vec_ready  (vec_ready),
    .vec_data   (vec_data),
    .vec_index  (vec_index),
    .rng_state_o(rng_state_o),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] lcg(input logic [31:0] x);
    logic [63:0] p;
    p = {32'd0, x} * 64'd1103515245 + 64'd12345;
    return p[31:0];
  endfunction

  function automatic logic [31:0] lcg_steps(input logic [31:0] s, input int n);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = lcg(r);
    return r;
  endfunction

  // Vector n of a run is built from LCG steps n*WORDS+1 .. n*WORDS+WORDS.
  function automatic logic [WIDTH-1:0] model_vector(input logic [31:0] s, input int n);
    logic [32*WORDS-1:0] wide;
    logic [31:0]         r;
    wide = '0;
    r = lcg_steps(s, n * WORDS);
    for (int k = 0; k < WORDS; k++) begin
      r = lcg(r);
      wide[32*k +: 32] = r;
    end
    return wide[WIDTH-1:0];
  endfunction

  task automatic start_pulse(input logic [31:0] s, input logic [31:0] n);
    @(negedge clk);
    start = 1'b1;
    seed = s;
    num_vectors = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output bit timed_out);
    int c;
    c = 0;
    while (!vec_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    timed_out = !vec_valid;
  endtask

  task automatic wait_done(output bit timed_out);
    int c;
    c = 0;
    while (!done && c < 200) begin
      @(negedge clk);
      c++;
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vectors++;
    if ({vec_valid, busy, done} !== 3'b000) begin
      n_miscompares++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {vec_valid, busy, done});
    end
    n_vectors++;
    if (vec_data !== '0) begin
      n_miscompares++;
      $display("[TB] FAIL reset_data: got %h expected 0", vec_data);
    end
    n_vectors++;
    if (vec_index !== 32'd0 || rng_state_o !== 32'd0) begin
      n_miscompares++;
      $display("[TB] FAIL reset_counters: got idx=%0d rng=%h expected 0/0", vec_index, rng_state_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] step9;
    vec_ready = 1'b1;
    start_pulse(32'd0, 32'd1);
    for (int i = 1; i <= WORDS; i++) begin
      @(negedge clk);
      n_vectors++;
      if (vec_valid !== ((i == WORDS) ? 1'b1 : 1'b0)) begin
        n_miscompares++;
        $display("[TB] FAIL basic_latency: edge %0d got valid=%b expected %b", i, vec_valid, (i == WORDS));
      end
    end
    step9 = lcg_steps(32'd0, WORDS);
    n_vectors++;
    if (vec_data[31:0] !== 32'h0000_3039) begin
      n_miscompares++;
      $display("[TB] FAIL basic_word0: got %h expected 00003039", vec_data[31:0]);
    end
    n_vectors++;
    if (vec_data[63:32] !== 32'hD3DC_167E) begin
      n_miscompares++;
      $display("[TB] FAIL basic_word1: got %h expected d3dc167e", vec_data[63:32]);
    end
    n_vectors++;
    if (vec_data[WIDTH-1:WIDTH-TOP_BITS] !== step9[TOP_BITS-1:0]) begin
      n_miscompares++;
      $display("[TB] FAIL basic_top: got %h expected %h", vec_data[WIDTH-1:WIDTH-TOP_BITS], step9[TOP_BITS-1:0]);
    end
    n_vectors++;
    if (rng_state_o !== step9) begin
      n_miscompares++;
      $display("[TB] FAIL basic_rng: got %h expected %h", rng_state_o, step9);
    end
    @(negedge clk);
    n_vectors++;
    if ({done, vec_valid} !== 2'b10 || vec_index !== 32'd1) begin
      n_miscompares++;
      $display("[TB] FAIL basic_done: got done=%b valid=%b idx=%0d expected 1/0/1", done, vec_valid, vec_index);
    end
    @(negedge clk);
    n_vectors++;
    if (done !== 1'b0) begin
      n_miscompares++;
      $display("[TB] FAIL basic_done_width: got done=%b expected 0", done);
    end
  endtask

  task automatic test_reset_mid_run();
    bit          to;
    logic [31:0] s;
    vec_ready = 1'b0;
    start_pulse(32'h1234_5678, 32'd3);
    wait_valid(to);
    n_vectors++;
    if (to) begin
      n_miscompares++;
      $display("[TB] FAIL midrst_wait: got no vec_valid expected vec_valid");
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vectors++;
    if ({vec_valid, busy, done} !== 3'b000 || vec_data !== '0 || vec_index !== 32'd0 || rng_state_o !== 32'd0) begin
      n_miscompares++;
      $display("[TB] FAIL midrst_async: got valid=%b busy=%b done=%b idx=%0d rng=%h expected all 0",
               vec_valid, busy, done, vec_index, rng_state_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    s = $urandom;
    vec_ready = 1'b1;
    start_pulse(s, 32'd1);
    wait_valid(to);
    n_vectors++;
    if (to || vec_data !== model_vector(s, 0)) begin
      n_miscompares++;
      $display("[TB] FAIL midrst_fresh: got %h expected %h", vec_data, model_vector(s, 0));
    end
    n_vectors++;
    if (rng_state_o !== lcg_steps(s, WORDS)) begin
      n_miscompares++;
      $display("[TB] FAIL midrst_rng: got %h expected %h", rng_state_o, lcg_steps(s, WORDS));
    end
    wait_done(to);
    n_vectors++;
    if (to || vec_index !== 32'd1) begin
      n_miscompares++;
      $display("[TB] FAIL midrst_end: got done=%b idx=%0d expected 1/1", done, vec_index);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit               to;
    logic [WIDTH-1:0] held_data;
    logic [31:0]      held_rng;
    logic [31:0]      step10;
    vec_ready = 1'b0;
    start_pulse(32'd0, 32'd2);
    wait_valid(to);
    held_data = vec_data;
    held_rng = rng_state_o;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vectors++;
      if (vec_valid !== 1'b1 || vec_data !== held_data || rng_state_o !== held_rng) begin
        n_miscompares++;
        $display("[TB] FAIL bp_stable: cycle %0d got valid=%b rng=%h expected 1 rng=%h", i, vec_valid, rng_state_o, held_rng);
      end
    end
    n_vectors++;
    if (vec_data !== model_vector(32'd0, 0)) begin
      n_miscompares++;
      $display("[TB] FAIL bp_vec0: got %h expected %h", vec_data, model_vector(32'd0, 0));
    end
    vec_ready = 1'b1;
    @(negedge clk);
    wait_valid(to);
    step10 = lcg_steps(32'd0, WORDS + 1);
    n_vectors++;
    if (to || vec_data[31:0] !== step10) begin
      n_miscompares++;
      $display("[TB] FAIL bp_vec1_word0: got %h expected %h", vec_data[31:0], step10);
    end
    n_vectors++;
    if (vec_data !== model_vector(32'd0, 1)) begin
      n_miscompares++;
      $display("[TB] FAIL bp_vec1: got %h expected %h", vec_data, model_vector(32'd0, 1));
    end
    wait_done(to);
    n_vectors++;
    if (to || vec_index !== 32'd2) begin
      n_miscompares++;
      $display("[TB] FAIL bp_end: got done=%b idx=%0d expected 1/2", done, vec_index);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_length();
    int dones;
    bit saw_valid;
    dones = 0;
    saw_valid = 1'b0;
    vec_ready = 1'b0;
    start_pulse($urandom, 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (done) dones++;
      if (vec_valid) saw_valid = 1'b1;
      @(negedge clk);
    end
    n_vectors++;
    if (dones != 1) begin
      n_miscompares++;
      $display("[TB] FAIL zero_done: got %0d pulses expected 1", dones);
    end
    n_vectors++;
    if (saw_valid || vec_index !== 32'd0 || busy !== 1'b0) begin
      n_miscompares++;
      $display("[TB] FAIL zero_outputs: got valid_seen=%b idx=%0d busy=%b expected 0/0/0", saw_valid, vec_index, busy);
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] s1;
    int          got;
    int          dones;
    s1 = $urandom;
    got = 0;
    dones = 0;
    vec_ready = 1'b1;
    start_pulse(s1, 32'd2);
    repeat (2) @(negedge clk);
    start = 1'b1;
    seed = s1 ^ 32'hDEAD_BEEF;
    num_vectors = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && dones == 0; c++) begin
      if (done) dones++;
      if (vec_valid) begin
        n_vectors++;
        if (vec_data !== model_vector(s1, got)) begin
          n_miscompares++;
          $display("[TB] FAIL busy_vec%0d: got %h expected %h", got, vec_data, model_vector(s1, got));
        end
        got++;
      end
      if (dones == 0) @(negedge clk);
    end
    n_vectors++;
    if (got != 2 || dones != 1 || vec_index !== 32'd2) begin
      n_miscompares++;
      $display("[TB] FAIL busy_count: got vecs=%0d done=%0d idx=%0d expected 2/1/2", got, dones, vec_index);
    end
    repeat (3) @(negedge clk);
    n_vectors++;
    if (busy !== 1'b0) begin
      n_miscompares++;
      $display("[TB] FAIL busy_ignored: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_full_run();
    logic [31:0]      s;
    logic [WIDTH-1:0] held_data;
    logic [31:0]      held_rng;
    int               got;
    int               dones;
    bit               pending;
    s = 32'd3289233844;
    got = 0;
    dones = 0;
    pending = 1'b0;
    held_data = '0;
    held_rng = '0;
    vec_ready = 1'b0;
    start_pulse(s, 32'd100);
    for (int c = 0; c < 6000 && dones == 0; c++) begin
      if (done) dones++;
      if (pending) begin
        n_vectors++;
        if (vec_valid !== 1'b1 || vec_data !== held_data || rng_state_o !== held_rng) begin
          n_miscompares++;
          $display("[TB] FAIL full_hold: vec %0d got valid=%b rng=%h expected 1 rng=%h", got, vec_valid, rng_state_o, held_rng);
        end
      end
      vec_ready = ($urandom_range(0, 1) == 1);
      if (vec_valid && vec_ready) begin
        n_vectors++;
        if (vec_data !== model_vector(s, got)) begin
          n_miscompares++;
          $display("[TB] FAIL full_vec%0d: got %h expected %h", got, vec_data, model_vector(s, got));
        end
        got++;
        pending = 1'b0;
      end else if (vec_valid) begin
        pending = 1'b1;
        held_data = vec_data;
        held_rng = rng_state_o;
      end
      @(negedge clk);
    end
    repeat (4) begin
      if (done) dones++;
      @(negedge clk);
    end
    n_vectors++;
    if (got != 100 || vec_index !== 32'd100) begin
      n_miscompares++;
      $display("[TB] FAIL full_count: got vecs=%0d idx=%0d expected 100/100", got, vec_index);
    end
    n_vectors++;
    if (dones != 1) begin
      n_miscompares++;
      $display("[TB] FAIL full_done: got %0d pulses expected 1", dones);
    end
  endtask

  initial begin
    $display("[TB] starting lcg_vector_source bench");
    test_reset();
    test_basic();
    test_reset_mid_run();
    test_backpressure();
    test_zero_length();
    test_start_while_busy();
    test_full_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
